// File: rtl/int_mul_add_seq.sv
// int_mul_add_seq: sequential shift-add multiply-accumulate.
// Computes prod = mul_a * mul_b + add_c (unsigned). One multiplier bit is
// retired per clock, so an operation always takes exactly WIDTH CALC cycles.
// When it is fed quotient/divisor/remainder it rebuilds the dividend.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The input side accepts only in IDLE. The output side holds
// out_valid, prod and fits_w stable in DONE until out_ready is seen.
module int_mul_add_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     mul_a,
  input  logic [WIDTH-1:0]     mul_b,
  input  logic [WIDTH-1:0]     add_c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   prod,
  output logic                 fits_w,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // The state register has a fixed name so checkers can bind to it.
  state_t               state;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcnd;
  logic [WIDTH-1:0]     mplr;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc_next;
  logic                 last_step;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // Partial-product step: add the shifted multiplicand when the current
  // multiplier bit is set. 2*WIDTH bits cannot overflow for these operands.
  always_comb begin
    acc_next  = acc;
    if (mplr[0]) begin
      acc_next = acc + mcnd;
    end
    last_step = (cnt == LAST_CNT);
  end

  // Ready and busy come straight from the state encoding.
  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
  end

  // Control FSM and datapath registers; prod/fits_w only change on the
  // CALC->DONE edge or on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      mcnd      <= '0;
      mplr      <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      prod      <= '0;
      fits_w    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= {{WIDTH{1'b0}}, add_c};
            mplr  <= mul_a;
            mcnd  <= {{WIDTH{1'b0}}, mul_b};
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          acc  <= acc_next;
          mplr <= mplr >> 1;
          mcnd <= mcnd << 1;
          cnt  <= cnt + 1'b1;
          if (last_step) begin
            prod      <= acc_next;
            fits_w    <= (acc_next[2*WIDTH-1:WIDTH] == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // in_valid is ignored here; only out_ready moves the FSM on.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
